// File: rtl/branch_station.sv
// branch_station: branch reservation station with a registered compare stage.
// Buffers conditional branches until both operands are known (snooping
// CDB_PORTS broadcast channels), evaluates the branch condition and presents
// {rob id, taken, next pc, mispredict} to the ROB over a valid/ready handshake.
//
// Ports:
//   clk_in, rst_n_in (async, active-low), flush_in (sync)
//   in_*   : decoder allocation side (in_valid/in_ready handshake)
//   cdb_*  : packed CDB channels, channel c at [c*W +: W], id 0 = idle
//   out_*  : result register towards the ROB (out_valid/out_ready handshake)
//   occupancy : number of busy entries
//
// Optional feature: define BRANCH_STATION_AGE_ORDER_EN to issue the oldest
// ready entry (per-entry age rank); otherwise the lowest-index ready entry.
module branch_station #(
  parameter int RS_SIZE   = 4,
  parameter int ROB_WIDTH = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          flush_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_op,
  input  logic [31:0]                   in_vj,
  input  logic [31:0]                   in_vk,
  input  logic [ROB_WIDTH-1:0]          in_qj,
  input  logic [ROB_WIDTH-1:0]          in_qk,
  input  logic [ROB_WIDTH-1:0]          in_dest,
  input  logic [31:0]                   in_pc_fallthrough,
  input  logic [31:0]                   in_pc_target,
  input  logic                          in_pred_taken,
  input  logic [CDB_PORTS*ROB_WIDTH-1:0] cdb_rob_id,
  input  logic [CDB_PORTS*32-1:0]       cdb_value,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROB_WIDTH-1:0]          out_rob_id,
  output logic                          out_taken,
  output logic [31:0]                   out_next_pc,
  output logic                          out_mispredict,
  output logic [$clog2(RS_SIZE+1)-1:0]  occupancy
);

  localparam int OCC_W = $clog2(RS_SIZE + 1);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   busy;
  logic [2:0]           op_q   [RS_SIZE];
  logic [31:0]          vj_q   [RS_SIZE];
  logic [31:0]          vk_q   [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj_q   [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk_q   [RS_SIZE];
  logic [ROB_WIDTH-1:0] dest_q [RS_SIZE];
  logic [31:0]          pcf_q  [RS_SIZE];
  logic [31:0]          pct_q  [RS_SIZE];
  logic [RS_SIZE-1:0]   pred_q;
`ifdef BRANCH_STATION_AGE_ORDER_EN
  logic [IDX_W-1:0]     age_q  [RS_SIZE];
`endif

  // {hit, value}; scanning high-to-low lets the lowest channel win ties.
  function automatic logic [32:0] snoop(input logic [ROB_WIDTH-1:0]           q,
                                        input logic [CDB_PORTS*ROB_WIDTH-1:0] ids,
                                        input logic [CDB_PORTS*32-1:0]        vals);
    logic [32:0] r;
    r = '0;
    for (int c = CDB_PORTS - 1; c >= 0; c--) begin
      if (q != '0 && ids[c*ROB_WIDTH +: ROB_WIDTH] == q) r = {1'b1, vals[c*32 +: 32]};
    end
    return r;
  endfunction

  logic [RS_SIZE-1:0] j_hit, k_hit, ready_vec;
  logic [31:0]        j_val [RS_SIZE];
  logic [31:0]        k_val [RS_SIZE];
  logic               in_j_hit, in_k_hit;
  logic [31:0]        in_j_val, in_k_val;
  logic [IDX_W-1:0]   free_idx, issue_idx;
  logic               alloc, out_free, issue_fire, taken;
  logic [31:0]        a, b;
  logic [OCC_W-1:0]   occ_cnt;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      {j_hit[i], j_val[i]} = snoop(qj_q[i], cdb_rob_id, cdb_value);
      {k_hit[i], k_val[i]} = snoop(qk_q[i], cdb_rob_id, cdb_value);
      ready_vec[i] = busy[i] && qj_q[i] == '0 && qk_q[i] == '0;
    end
    {in_j_hit, in_j_val} = snoop(in_qj, cdb_rob_id, cdb_value);
    {in_k_hit, in_k_val} = snoop(in_qk, cdb_rob_id, cdb_value);
  end

  always_comb begin
    free_idx = '0;
    occ_cnt  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      occ_cnt = occ_cnt + OCC_W'(busy[i]);
    end
  end

  assign in_ready   = ~&busy;
  assign alloc      = in_valid && in_ready;
  assign out_free   = !out_valid || out_ready;
  assign issue_fire = |ready_vec && out_free;
  assign occupancy  = occ_cnt;

`ifdef BRANCH_STATION_AGE_ORDER_EN
  logic [IDX_W-1:0] best_age;
  logic             found;
  always_comb begin
    issue_idx = '0;
    best_age  = '0;
    found     = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready_vec[i] && (!found || age_q[i] < best_age)) begin
        found     = 1'b1;
        issue_idx = IDX_W'(i);
        best_age  = age_q[i];
      end
    end
  end
`else
  always_comb begin
    issue_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready_vec[i]) issue_idx = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    a = vj_q[issue_idx];
    b = vk_q[issue_idx];
    case (op_q[issue_idx])
      3'b000:  taken = a == b;
      3'b001:  taken = a != b;
      3'b100:  taken = $signed(a) <  $signed(b);
      3'b101:  taken = $signed(a) >= $signed(b);
      3'b110:  taken = a <  b;
      3'b111:  taken = a >= b;
      default: taken = 1'b0;
    endcase
  end

  // Control state: busy bits, ages and the output register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy           <= '0;
      out_valid      <= 1'b0;
      out_rob_id     <= '0;
      out_taken      <= 1'b0;
      out_next_pc    <= '0;
      out_mispredict <= 1'b0;
`ifdef BRANCH_STATION_AGE_ORDER_EN
      for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
`endif
    end else if (flush_in) begin
      busy      <= '0;
      out_valid <= 1'b0;
    end else begin
      if (issue_fire) busy[issue_idx] <= 1'b0;
      // in_ready came from the pre-issue busy vector, so free_idx never
      // collides with the entry issuing this cycle.
      if (alloc) busy[free_idx] <= 1'b1;
      if (out_free) begin
        out_valid <= issue_fire;
        if (issue_fire) begin
          out_rob_id     <= dest_q[issue_idx];
          out_taken      <= taken;
          out_next_pc    <= taken ? pct_q[issue_idx] : pcf_q[issue_idx];
          out_mispredict <= taken ^ pred_q[issue_idx];
        end
      end
`ifdef BRANCH_STATION_AGE_ORDER_EN
      if (issue_fire) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && age_q[i] > age_q[issue_idx]) age_q[i] <= age_q[i] - 1'b1;
        end
      end
      if (alloc) age_q[free_idx] <= IDX_W'(occ_cnt - OCC_W'(issue_fire));
`endif
    end
  end

  // Entry payload; meaningless while the entry is not busy, so no reset.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy[i] && j_hit[i]) begin
        vj_q[i] <= j_val[i];
        qj_q[i] <= '0;
      end
      if (busy[i] && k_hit[i]) begin
        vk_q[i] <= k_val[i];
        qk_q[i] <= '0;
      end
    end
    if (alloc) begin
      op_q[free_idx]   <= in_op;
      vj_q[free_idx]   <= in_j_hit ? in_j_val : in_vj;
      qj_q[free_idx]   <= in_j_hit ? '0 : in_qj;
      vk_q[free_idx]   <= in_k_hit ? in_k_val : in_vk;
      qk_q[free_idx]   <= in_k_hit ? '0 : in_qk;
      dest_q[free_idx] <= in_dest;
      pcf_q[free_idx]  <= in_pc_fallthrough;
      pct_q[free_idx]  <= in_pc_target;
      pred_q[free_idx] <= in_pred_taken;
    end
  end

endmodule

// File: tb/tb_branch_station.sv
module tb_branch_station;
  localparam int RS = 4;
  localparam int RW = 4;
  localparam int CP = 2;
  localparam int OW = $clog2(RS + 1);

  logic            clk_in = 1'b0;
  logic            rst_n_in = 1'b0;
  logic            flush_in = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_op = '0;
  logic [31:0]     in_vj = '0, in_vk = '0;
  logic [RW-1:0]   in_qj = '0, in_qk = '0, in_dest = '0;
  logic [31:0]     in_pc_fallthrough = '0, in_pc_target = '0;
  logic            in_pred_taken = 1'b0;
  logic [CP*RW-1:0] cdb_rob_id = '0;
  logic [CP*32-1:0] cdb_value = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [RW-1:0]   out_rob_id;
  logic            out_taken;
  logic [31:0]     out_next_pc;
  logic            out_mispredict;
  logic [OW-1:0]   occupancy;

  always #5 clk_in = ~clk_in;

  branch_station #(.RS_SIZE(RS), .ROB_WIDTH(RW), .CDB_PORTS(CP)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_vj(in_vj), .in_vk(in_vk), .in_qj(in_qj), .in_qk(in_qk),
    .in_dest(in_dest), .in_pc_fallthrough(in_pc_fallthrough),
    .in_pc_target(in_pc_target), .in_pred_taken(in_pred_taken),
    .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob_id(out_rob_id),
    .out_taken(out_taken), .out_next_pc(out_next_pc),
    .out_mispredict(out_mispredict), .occupancy(occupancy)
  );

  typedef struct packed {
    logic [RW-1:0] rob;
    logic          taken;
    logic [31:0]   pc;
    logic          mis;
  } res_t;

  res_t sb[$];
  res_t got, exp_r;
  int   n_cmp = 0;
  int   n_err = 0;

  always_comb got = {out_rob_id, out_taken, out_next_pc, out_mispredict};

  function automatic res_t mk_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [RW-1:0] dest, input logic [31:0] ft,
                                  input logic [31:0] tgt, input logic pred);
    res_t r;
    logic t;
    case (op)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) < $signed(b));
      3'b101:  t = !($signed(a) < $signed(b));
      3'b110:  t = (a < b);
      3'b111:  t = !(a < b);
      default: t = 1'b0;
    endcase
    r.rob = dest; r.taken = t; r.pc = t ? tgt : ft; r.mis = (t != pred);
    return r;
  endfunction

  task automatic put_branch(input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [RW-1:0] qj, input logic [RW-1:0] qk,
                            input logic [RW-1:0] dest, input logic [31:0] ft,
                            input logic [31:0] tgt, input logic pred);
    in_valid = 1'b1; in_op = op; in_vj = vj; in_vk = vk; in_qj = qj; in_qk = qk;
    in_dest = dest; in_pc_fallthrough = ft; in_pc_target = tgt; in_pred_taken = pred;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_qj = '0; in_qk = '0;
    cdb_rob_id = '0; cdb_value = '0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; idle(); out_ready = 1'b0; flush_in = 1'b0;
    repeat (2) @(negedge clk_in);
    n_cmp++;
    if ({out_valid, out_rob_id, out_taken, out_next_pc, out_mispredict, occupancy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {out_valid, out_rob_id, out_taken, out_next_pc, out_mispredict, occupancy});
    end
    rst_n_in = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    sb.delete();
    out_ready = 1'b1;
    put_branch(3'b000, 32'd5, 32'd5, 4'd0, 4'd0, 4'd3, 32'h8, 32'h100, 1'b0);
    sb.push_back(mk_exp(3'b000, 32'd5, 32'd5, 4'd3, 32'h8, 32'h100, 1'b0));
    @(negedge clk_in); idle();
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== OW'(1)) begin
      n_err++; $display("FAIL basic_pending: got valid=%b occ=%0d expected valid=0 occ=1", out_valid, occupancy);
    end
    @(negedge clk_in);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    else begin
      exp_r = sb.pop_front();
      n_cmp++;
      if (got !== exp_r) begin n_err++; $display("FAIL basic_result: got %h expected %h", got, exp_r); end
    end
    @(negedge clk_in);
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== OW'(0)) begin
      n_err++; $display("FAIL basic_drain: got valid=%b occ=%0d expected valid=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_cdb_wakeup();
    logic [2:0]    ops  [3] = '{3'b100, 3'b110, 3'b110};
    logic [31:0]   vks  [3] = '{32'd0, 32'd0, 32'd5};
    logic [RW-1:0] id0  [3] = '{4'd0, 4'd0, 4'd2};
    logic [31:0]   val0 [3] = '{32'd0, 32'd0, 32'd1};
    logic [31:0]   val1 [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0]   rvj  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    logic          prd  [3] = '{1'b0, 1'b0, 1'b1};
    sb.delete();
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      put_branch(ops[r], 32'hDEAD_BEEF, vks[r], 4'd2, 4'd0, RW'(4 + r), 32'h10, 32'h200, prd[r]);
      sb.push_back(mk_exp(ops[r], rvj[r], vks[r], RW'(4 + r), 32'h10, 32'h200, prd[r]));
      @(negedge clk_in); idle();
      @(negedge clk_in);
      n_cmp++;
      if (out_valid !== 1'b0 || occupancy !== OW'(1)) begin
        n_err++; $display("FAIL cdb_waiting[%0d]: got valid=%b occ=%0d expected valid=0 occ=1", r, out_valid, occupancy);
      end
      cdb_rob_id = {4'd2, id0[r]};
      cdb_value  = {val1[r], val0[r]};
      @(negedge clk_in); idle();
      @(negedge clk_in);
      n_cmp++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL cdb_valid[%0d]: got %b expected 1", r, out_valid); end
      else begin
        exp_r = sb.pop_front();
        n_cmp++;
        if (got !== exp_r) begin n_err++; $display("FAIL cdb_result[%0d]: got %h expected %h", r, got, exp_r); end
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_full_stall();
    res_t e [5];
    logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b111};
    int order [5];
`ifdef BRANCH_STATION_AGE_ORDER_EN
    order = '{0, 1, 2, 3, 4};
`else
    order = '{0, 2, 1, 3, 4};
`endif
    sb.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e[i] = mk_exp(ops[i], 32'(i * 3), 32'd6, RW'(i + 1), 32'(16 * i), 32'(16 * i + 8), 1'b0);
      put_branch(ops[i], 32'(i * 3), 32'd6, 4'd0, 4'd0, RW'(i + 1), 32'(16 * i), 32'(16 * i + 8), 1'b0);
      @(negedge clk_in);
    end
    idle();
    for (int i = 0; i < 5; i++) sb.push_back(e[order[i]]);
    n_cmp++;
    if (in_ready !== 1'b0 || occupancy !== OW'(RS)) begin
      n_err++; $display("FAIL full_state: got in_ready=%b occ=%0d expected 0/%0d", in_ready, occupancy, RS);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || got !== sb[0]) begin
      n_err++; $display("FAIL stall_head: got valid=%b %h expected 1 %h", out_valid, got, sb[0]);
    end
    put_branch(3'b001, 32'd1, 32'd2, 4'd0, 4'd0, 4'd15, 32'h0, 32'h4, 1'b1);
    @(negedge clk_in); idle();
    @(negedge clk_in);
    n_cmp++;
    if (occupancy !== OW'(RS) || out_valid !== 1'b1 || got !== sb[0]) begin
      n_err++; $display("FAIL stall_hold: got occ=%0d valid=%b %h expected %0d 1 %h", occupancy, out_valid, got, RS, sb[0]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || occupancy !== OW'(4 - i)) begin
        n_err++; $display("FAIL drain_state[%0d]: got valid=%b occ=%0d expected 1 %0d", i, out_valid, occupancy, 4 - i);
      end else begin
        exp_r = sb.pop_front();
        n_cmp++;
        if (got !== exp_r) begin n_err++; $display("FAIL drain_result[%0d]: got %h expected %h", i, got, exp_r); end
      end
      @(negedge clk_in);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_age_order();
    res_t ex, ea, eb;
    sb.delete();
    out_ready = 1'b0;
    ex = mk_exp(3'b000, 32'd1, 32'd1, 4'd8, 32'h20, 32'h40, 1'b1);
    ea = mk_exp(3'b001, 32'd7, 32'd0, 4'd9, 32'h24, 32'h44, 1'b1);
    eb = mk_exp(3'b110, 32'd1, 32'd2, 4'd10, 32'h28, 32'h48, 1'b0);
    put_branch(3'b000, 32'd1, 32'd1, 4'd0, 4'd0, 4'd8, 32'h20, 32'h40, 1'b1);
    @(negedge clk_in);
    put_branch(3'b001, 32'hDEAD_BEEF, 32'd0, 4'd5, 4'd0, 4'd9, 32'h24, 32'h44, 1'b1);
    @(negedge clk_in);
    put_branch(3'b110, 32'd1, 32'd2, 4'd0, 4'd0, 4'd10, 32'h28, 32'h48, 1'b0);
    @(negedge clk_in); idle();
    cdb_rob_id = {4'd0, 4'd5};
    cdb_value  = {32'd0, 32'd7};
    @(negedge clk_in); idle();
    sb.push_back(ex);
`ifdef BRANCH_STATION_AGE_ORDER_EN
    sb.push_back(ea); sb.push_back(eb);
`else
    sb.push_back(eb); sb.push_back(ea);
`endif
    n_cmp++;
    if (occupancy !== OW'(2)) begin n_err++; $display("FAIL age_occ: got %0d expected 2", occupancy); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL age_valid[%0d]: got %b expected 1", i, out_valid); end
      else begin
        exp_r = sb.pop_front();
        n_cmp++;
        if (got !== exp_r) begin n_err++; $display("FAIL age_result[%0d]: got %h expected %h", i, got, exp_r); end
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_bypass();
    sb.delete();
    out_ready = 1'b1;
    // Both operands resolved by the CDB in the allocation cycle.
    put_branch(3'b111, 32'd0, 32'hFFFF_FFFF, 4'd6, 4'd7, 4'd11, 32'h30, 32'h50, 1'b0);
    cdb_rob_id = {4'd7, 4'd6};
    cdb_value  = {32'd5, 32'h8000_0000};
    sb.push_back(mk_exp(3'b111, 32'h8000_0000, 32'd5, 4'd11, 32'h30, 32'h50, 1'b0));
    @(negedge clk_in); idle();
    @(negedge clk_in);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL bypass_valid: got %b expected 1", out_valid); end
    else begin
      exp_r = sb.pop_front();
      n_cmp++;
      if (got !== exp_r) begin n_err++; $display("FAIL bypass_result: got %h expected %h", got, exp_r); end
    end
    @(negedge clk_in);
  endtask

  task automatic test_back_to_back();
    logic [31:0] va, vb;
    sb.delete();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        va = $urandom();
        vb = (i % 2 == 0) ? va : $urandom();
        if (i == 4) begin va = 32'h7FFF_FFFF; vb = 32'h8000_0000; end
        put_branch(3'(i), va, vb, 4'd0, 4'd0, RW'(i + 1), 32'(i * 4), 32'(i * 4 + 2), i[1]);
        sb.push_back(mk_exp(3'(i), va, vb, RW'(i + 1), 32'(i * 4), 32'(i * 4 + 2), i[1]));
      end else idle();
      @(negedge clk_in);
      if (i >= 1) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i - 1, out_valid); end
        else begin
          exp_r = sb.pop_front();
          n_cmp++;
          if (got !== exp_r) begin n_err++; $display("FAIL b2b_result[%0d]: got %h expected %h", i - 1, got, exp_r); end
        end
      end
    end
    @(negedge clk_in);
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== OW'(0)) begin
      n_err++; $display("FAIL b2b_empty: got valid=%b occ=%0d expected 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush_reset();
    sb.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put_branch(3'b000, 32'd1, 32'd1, 4'd0, 4'd0, RW'(i + 1), 32'h0, 32'h80, 1'b0);
      @(negedge clk_in);
    end
    idle();
    n_cmp++;
    if (occupancy !== OW'(3) || out_valid !== 1'b1) begin
      n_err++; $display("FAIL preflush: got occ=%0d valid=%b expected 3 1", occupancy, out_valid);
    end
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    n_cmp++;
    if (occupancy !== OW'(0) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush: got occ=%0d valid=%b in_ready=%b expected 0 0 1", occupancy, out_valid, in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      put_branch(3'b001, 32'd1, 32'd2, 4'd0, 4'd0, RW'(12 + i), 32'h4, 32'hC, 1'b0);
      @(negedge clk_in);
    end
    idle();
    @(negedge clk_in);
    n_cmp++;
    if (occupancy !== OW'(1) || out_valid !== 1'b1) begin
      n_err++; $display("FAIL prereset: got occ=%0d valid=%b expected 1 1", occupancy, out_valid);
    end
    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_rob_id, out_taken, out_next_pc, out_mispredict, occupancy} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got %h expected 0",
               {out_valid, out_rob_id, out_taken, out_next_pc, out_mispredict, occupancy});
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_cdb_wakeup();
    test_full_stall();
    test_age_order();
    test_bypass();
    test_back_to_back();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
